// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hard-wired T-state control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7,
    StHalt = 4'd8
  } state_e;

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpSll  = 5'b00011;
  localparam logic [4:0] OpSrl  = 5'b00100;
  localparam logic [4:0] OpSra  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpMul  = 5'b01001;
  localparam logic [4:0] OpDiv  = 5'b01010;
  localparam logic [4:0] OpNeg  = 5'b01011;
  localparam logic [4:0] OpNot  = 5'b01100;
  localparam logic [4:0] OpNop  = 5'b01101;
  localparam logic [4:0] OpHalt = 5'b01110;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned RaMsb     = 26;
  localparam int unsigned RaLsb     = 23;
  localparam int unsigned RbMsb     = 22;
  localparam int unsigned RbLsb     = 19;
  localparam int unsigned RcMsb     = 18;
  localparam int unsigned RcLsb     = 15;

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/ir_field_decoder.sv
// Combinational IR decode: one-hot register selects and instruction class flags.
module ir_field_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [15:0] ra_oh_o,
  output logic [15:0] rb_oh_o,
  output logic [15:0] rc_oh_o,
  output logic        is_unary_o,
  output logic        is_muldiv_o,
  output logic        is_nop_o,
  output logic        is_halt_o
);

  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir_i[OpcodeMsb:OpcodeLsb];
  assign unused_ir = ^ir_i[RcLsb-1:0];

  assign ra_oh_o = reg_onehot(ir_i[RaMsb:RaLsb]);
  assign rb_oh_o = reg_onehot(ir_i[RbMsb:RbLsb]);
  assign rc_oh_o = reg_onehot(ir_i[RcMsb:RcLsb]);

  always_comb begin
    is_unary_o  = 1'b0;
    is_muldiv_o = 1'b0;
    is_nop_o    = 1'b0;
    is_halt_o   = 1'b0;
    case (opcode)
      OpAdd, OpSub, OpAnd, OpSll, OpSrl, OpSra, OpOr, OpRor, OpRol: ;
      OpMul, OpDiv: is_muldiv_o = 1'b1;
      OpNeg, OpNot: is_unary_o  = 1'b1;
      OpHalt:       is_halt_o   = 1'b1;
      OpNop:        is_nop_o    = 1'b1;
      // Undefined opcodes fall through as NOP.
      default:      is_nop_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired T-state sequencer driving the data_path strobes (fetch + register ALU ops).
// Optional INSTR_COUNT_EN adds a retired-instruction counter output.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MARin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        Zlowin,
  output logic        ZHighin,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  op,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        busy,
  output logic        done,
  output logic        halted
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        is_unary, is_muldiv, is_nop, is_halt;
  state_e      after_done;

  ir_field_decoder u_ir_field_decoder (
    .ir_i        (IR),
    .ra_oh_o     (ra_oh),
    .rb_oh_o     (rb_oh),
    .rc_oh_o     (rc_oh),
    .is_unary_o  (is_unary),
    .is_muldiv_o (is_muldiv),
    .is_nop_o    (is_nop),
    .is_halt_o   (is_halt)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign after_done = run ? StT0 : StIdle;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: if (run) state_d = StT0;
      StT0:   state_d = StT1;
      StT1: begin
        if (wait_q == WaitLast) begin
          state_d = StT2;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StT2: state_d = StT3;
      StT3: begin
        if (is_halt)     state_d = StHalt;
        else if (is_nop) state_d = after_done;
        else             state_d = StT4;
      end
      StT4:   state_d = StT5;
      StT5:   state_d = is_muldiv ? StT6 : after_done;
      StT6:   state_d = after_done;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Moore decode: strobes depend on state (and the stable IR from T3 on) only.
  always_comb begin
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    MDRin    = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Zlowin   = 1'b0;
    ZHighin  = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    op       = 5'b00000;
    Rout     = '0;
    Rin      = '0;
    done     = 1'b0;
    busy     = (state_q != StIdle) && (state_q != StHalt);
    halted   = (state_q == StHalt);
    case (state_q)
      StT0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = (wait_q == WaitLast);
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (is_nop) begin
          done = 1'b1;
        end else if (!is_halt) begin
          Rout = rb_oh;
          Yin  = 1'b1;
        end
      end
      StT4: begin
        Rout    = is_unary ? 16'h0000 : rc_oh;
        op      = IR[OpcodeMsb:OpcodeLsb];
        Zlowin  = 1'b1;
        ZHighin = is_muldiv;
      end
      StT5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin  = ra_oh;
          done = 1'b1;
        end
      end
      StT6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge Clock) begin
    if (clear)     count_q <= '0;
    else if (done) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`endif

  assert property (@(posedge Clock) disable iff (clear)
    $onehot0(Rout) && $onehot0(Rin) && $onehot0({PCout, MDRout, Zlowout, Zhighout, |Rout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer; two instances (MEM_WAIT 0 and 3).
module tb_control_sequencer;

  typedef struct packed {
    logic pc_out, mdr_out, zlo_out, zhi_out, mar_in, pc_in, ir_in, y_in, mdr_in;
    logic hi_in, lo_in, zlo_in, zhi_in, inc_pc, read;
    logic [4:0]  op;
    logic [15:0] rout, rin;
    logic busy, done, halted;
  } vec_t;

  localparam int NDir    = 6;
  localparam int NCycles = 1500;

  logic        clk = 1'b0;
  logic        clear_v [2];
  logic        run_v   [2];
  logic [31:0] ir_v    [2];
  vec_t        act     [2];
  logic [31:0] cnt_act [2];

  vec_t        sb_q  [2][$];
  logic [31:0] cnt_q [2][$];
  vec_t        tr    [2][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic PCout, MDRout, Zlowout, Zhighout, MARin, PCin, IRin, Yin, MDRin;
    logic HIin, LOin, Zlowin, ZHighin, IncPC, Read, busy, done, halted;
    logic [4:0]  op;
    logic [15:0] Rout, Rin;
`ifdef INSTR_COUNT_EN
    logic [31:0] ic;
    assign cnt_act[k] = ic;
`else
    assign cnt_act[k] = '0;
`endif

    control_sequencer #(.MEM_WAIT((k == 0) ? 0 : 3)) u_dut (
      .Clock    (clk),
      .clear    (clear_v[k]),
      .run      (run_v[k]),
      .IR       (ir_v[k]),
      .PCout    (PCout),
      .MDRout   (MDRout),
      .Zlowout  (Zlowout),
      .Zhighout (Zhighout),
      .MARin    (MARin),
      .PCin     (PCin),
      .IRin     (IRin),
      .Yin      (Yin),
      .MDRin    (MDRin),
      .HIin     (HIin),
      .LOin     (LOin),
      .Zlowin   (Zlowin),
      .ZHighin  (ZHighin),
      .IncPC    (IncPC),
      .Read     (Read),
      .op       (op),
      .Rout     (Rout),
      .Rin      (Rin),
      .busy     (busy),
      .done     (done),
      .halted   (halted)
`ifdef INSTR_COUNT_EN
      ,
      .instr_count (ic)
`endif
    );

    assign act[k] = {PCout, MDRout, Zlowout, Zhighout, MARin, PCin, IRin, Yin, MDRin,
                     HIin, LOin, Zlowin, ZHighin, IncPC, Read, op, Rout, Rin,
                     busy, done, halted};
  end

  // Directed instructions issued first: SLL, MUL, NOT, then ADDs (HALT last on instance 1).
  function automatic logic [31:0] dir_ir(input int k, input int i);
    if (k == 1 && i == NDir - 1) return 32'h7000_0000;
    case (i)
      0:       return 32'h1899_0000;
      1:       return 32'h4A28_0000;
      2:       return 32'h63B0_0000;
      default: return 32'h0091_8000;
    endcase
  endfunction

  // Expected strobe trace of one instruction, straight from the T-state rules.
  function automatic void build(input int k, input logic [31:0] ir, input int mw);
    vec_t v;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic muldiv, unary;
    opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    muldiv = (opc == 5'd9) || (opc == 5'd10);
    unary  = (opc == 5'd11) || (opc == 5'd12);
    v = '0; v.busy = 1; v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.zlo_in = 1;
    tr[k].push_back(v);
    for (int i = 0; i <= mw; i++) begin
      v = '0; v.busy = 1; v.zlo_out = 1; v.read = 1; v.mdr_in = 1; v.pc_in = (i == mw);
      tr[k].push_back(v);
    end
    v = '0; v.busy = 1; v.mdr_out = 1; v.ir_in = 1;
    tr[k].push_back(v);
    v = '0; v.busy = 1;
    if (opc == 5'd13 || opc > 5'd14) begin
      v.done = 1;
      tr[k].push_back(v);
      return;
    end
    if (opc == 5'd14) begin
      tr[k].push_back(v);
      return;
    end
    v.rout = 16'(1) << rb; v.y_in = 1;
    tr[k].push_back(v);
    v = '0; v.busy = 1; v.rout = unary ? 16'h0 : (16'(1) << rc); v.op = opc;
    v.zlo_in = 1; v.zhi_in = muldiv;
    tr[k].push_back(v);
    v = '0; v.busy = 1; v.zlo_out = 1;
    if (muldiv) v.lo_in = 1;
    else begin v.rin = 16'(1) << ra; v.done = 1; end
    tr[k].push_back(v);
    if (muldiv) begin
      v = '0; v.busy = 1; v.zhi_out = 1; v.hi_in = 1; v.done = 1;
      tr[k].push_back(v);
    end
  endfunction

  task automatic drive(input int k, input int mw);
    vec_t        cur, halt_v;
    logic [31:0] cnt, nir;
    int          mode, idx, halt_cycles;
    bit          pend_halt, did_mid_clear;
    halt_v = '0; halt_v.halted = 1;
    cur = '0; cnt = 0; mode = 0; idx = 0; halt_cycles = 0;
    pend_halt = 0; did_mid_clear = 0;
    clear_v[k] = 1; run_v[k] = 1; ir_v[k] = '0;
    for (int cyc = 0; cyc < NCycles; cyc++) begin
      @(posedge clk);
      #1;
      if (clear_v[k]) begin
        mode = 0; tr[k].delete(); pend_halt = 0; cur = '0; cnt = 0;
      end else begin
        if (cur.done) cnt = cnt + 1;
        if (mode == 2) cur = halt_v;
        else if (tr[k].size() > 0) cur = tr[k].pop_front();
        else if (pend_halt) begin
          mode = 2; pend_halt = 0; cur = halt_v;
        end else if (run_v[k]) begin
          if (idx < NDir) begin
            nir = dir_ir(k, idx);
            idx++;
          end else begin
            nir = $urandom();
            nir[31:27] = 5'($urandom_range(0, 31));
          end
          ir_v[k] = nir;
          build(k, nir, mw);
          pend_halt = (nir[31:27] == 5'd14);
          cur = tr[k].pop_front();
          mode = 1;
        end else begin
          cur = '0; mode = 0;
        end
      end
      sb_q[k].push_back(cur);
      cnt_q[k].push_back(cnt);
      halt_cycles = (mode == 2) ? halt_cycles + 1 : 0;
      if (cyc < 1) begin
        clear_v[k] = 1; run_v[k] = 1;
      end else if (idx < NDir || pend_halt || (tr[k].size() > 0 && idx == NDir && cyc < 80)) begin
        clear_v[k] = 0; run_v[k] = 1;
      end else begin
        run_v[k]   = ($urandom_range(0, 7) != 0);
        clear_v[k] = ($urandom_range(0, 96) == 0) || (halt_cycles > 4);
        // One deliberate abort in the middle of T4.
        if (!did_mid_clear && cur.zlo_in && !cur.inc_pc) begin
          clear_v[k] = 1; did_mid_clear = 1;
        end
      end
    end
    clear_v[k] = 1;
  endtask

  always @(negedge clk) begin
    vec_t        e;
    logic [31:0] ce;
    for (int k = 0; k < 2; k++) begin
      if (sb_q[k].size() > 0) begin
        e  = sb_q[k].pop_front();
        ce = cnt_q[k].pop_front();
        checks++;
        if (act[k] !== e) begin
          errors++;
          $display("FAIL strobes u%0d t=%0t: got %h, want %h", k, $time, act[k], e);
        end
`ifdef INSTR_COUNT_EN
        checks++;
        if (cnt_act[k] !== ce) begin
          errors++;
          $display("FAIL instr_count u%0d t=%0t: got %0d, want %0d", k, $time, cnt_act[k], ce);
        end
`endif
      end
    end
  end

  initial begin
    clear_v[0] = 1; clear_v[1] = 1;
    run_v[0]   = 1; run_v[1]   = 1;
    ir_v[0]    = '0; ir_v[1]   = '0;
    fork
      drive(0, 0);
      drive(1, 3);
    join
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
